// File: rtl/iou_arbiter.sv
// Two-requester (CPU/MAU) arbiter for a single IO-unit port: one pending slot per requester,
// round-robin grant, fixed ISSUE/WAIT/RESP access timing with a parameterised read latency.
module iou_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alive,
  input  logic        cpu_req,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_data_write,
  input  logic        cpu_wren,
  output logic        cpu_busy,
  output logic        cpu_ack,
  output logic [31:0] cpu_data_read,
  output logic        cpu_overrun,
  input  logic        mau_req,
  input  logic [31:0] mau_address,
  input  logic [31:0] mau_data_write,
  input  logic        mau_wren,
  output logic        mau_busy,
  output logic        mau_ack,
  output logic [31:0] mau_data_read,
  output logic        mau_overrun,
  output logic        iou_clk_en,
  output logic [31:0] iou_address,
  output logic [31:0] iou_data_write,
  output logic        iou_wren,
  input  logic [31:0] iou_data_read
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [2:0] LastCnt = 3'(READ_LATENCY - 1);

  state_e      state_q;
  logic        cpu_vld_q, mau_vld_q;
  logic [31:0] cpu_addr_q, cpu_wdata_q, mau_addr_q, mau_wdata_q;
  logic        cpu_wr_q, mau_wr_q;
  logic        gnt_mau_q, gnt_wr_q, last_mau_q;
  logic [2:0]  cnt_q;

  logic in_flight, cpu_elig, mau_elig, pick_mau;

  always_comb begin
    in_flight = (state_q == StIssue) || (state_q == StWait);
    // The slot is freed at the end of ISSUE, so the in-flight owner stays busy through WAIT.
    cpu_busy  = cpu_vld_q || (in_flight && !gnt_mau_q);
    mau_busy  = mau_vld_q || (in_flight && gnt_mau_q);
    cpu_elig  = cpu_vld_q && alive;
    mau_elig  = mau_vld_q;
    pick_mau  = mau_elig && (!cpu_elig || !last_mau_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cpu_vld_q      <= 1'b0;
      mau_vld_q      <= 1'b0;
      cpu_addr_q     <= '0;
      cpu_wdata_q    <= '0;
      cpu_wr_q       <= 1'b0;
      mau_addr_q     <= '0;
      mau_wdata_q    <= '0;
      mau_wr_q       <= 1'b0;
      gnt_mau_q      <= 1'b0;
      gnt_wr_q       <= 1'b0;
      last_mau_q     <= 1'b1;
      cnt_q          <= '0;
      cpu_ack        <= 1'b0;
      mau_ack        <= 1'b0;
      cpu_data_read  <= '0;
      mau_data_read  <= '0;
      cpu_overrun    <= 1'b0;
      mau_overrun    <= 1'b0;
      iou_clk_en     <= 1'b0;
      iou_address    <= '0;
      iou_data_write <= '0;
      iou_wren       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_elig || mau_elig) begin
            state_q        <= StIssue;
            gnt_mau_q      <= pick_mau;
            last_mau_q     <= pick_mau;
            gnt_wr_q       <= pick_mau ? mau_wr_q : cpu_wr_q;
            iou_clk_en     <= 1'b1;
            iou_address    <= pick_mau ? mau_addr_q : cpu_addr_q;
            iou_data_write <= pick_mau ? mau_wdata_q : cpu_wdata_q;
            iou_wren       <= pick_mau ? mau_wr_q : cpu_wr_q;
          end
        end
        StIssue: begin
          state_q        <= StWait;
          cnt_q          <= '0;
          iou_clk_en     <= 1'b0;
          iou_address    <= '0;
          iou_data_write <= '0;
          iou_wren       <= 1'b0;
          if (gnt_mau_q) mau_vld_q <= 1'b0;
          else           cpu_vld_q <= 1'b0;
        end
        StWait: begin
          if (cnt_q == LastCnt) begin
            state_q <= StResp;
            if (gnt_mau_q) begin
              mau_ack <= 1'b1;
              if (!gnt_wr_q) mau_data_read <= iou_data_read;
            end else begin
              cpu_ack <= 1'b1;
              if (!gnt_wr_q) cpu_data_read <= iou_data_read;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          cpu_ack <= 1'b0;
          mau_ack <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      // A busy requester can never have its slot cleared in the same cycle, so loads and the
      // ISSUE-time clear never collide.
      if (cpu_req) begin
        if (cpu_busy) begin
          cpu_overrun <= 1'b1;
        end else begin
          cpu_vld_q   <= 1'b1;
          cpu_addr_q  <= cpu_address;
          cpu_wdata_q <= cpu_data_write;
          cpu_wr_q    <= cpu_wren;
        end
      end
      if (mau_req) begin
        if (mau_busy) begin
          mau_overrun <= 1'b1;
        end else begin
          mau_vld_q   <= 1'b1;
          mau_addr_q  <= mau_address;
          mau_wdata_q <= mau_data_write;
          mau_wr_q    <= mau_wren;
        end
      end
    end
  end

endmodule

// File: tb/tb_iou_arbiter.sv
// Self-checking bench for iou_arbiter: directed table, corner-case sequences and random traffic
// compared every cycle against a transaction-timing reference model.
module tb_iou_arbiter;
  localparam int unsigned L = 1;

  logic        clk = 1'b0;
  logic        reset, alive;
  logic        cpu_req, cpu_wren, mau_req, mau_wren;
  logic [31:0] cpu_address, cpu_data_write, mau_address, mau_data_write, iou_data_read;
  logic        cpu_busy, cpu_ack, cpu_overrun, mau_busy, mau_ack, mau_overrun;
  logic [31:0] cpu_data_read, mau_data_read, iou_address, iou_data_write;
  logic        iou_clk_en, iou_wren;

  always #5 clk = ~clk;

  iou_arbiter #(.READ_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .alive(alive),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data_write(cpu_data_write),
    .cpu_wren(cpu_wren), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack),
    .cpu_data_read(cpu_data_read), .cpu_overrun(cpu_overrun),
    .mau_req(mau_req), .mau_address(mau_address), .mau_data_write(mau_data_write),
    .mau_wren(mau_wren), .mau_busy(mau_busy), .mau_ack(mau_ack),
    .mau_data_read(mau_data_read), .mau_overrun(mau_overrun),
    .iou_clk_en(iou_clk_en), .iou_address(iou_address), .iou_data_write(iou_data_write),
    .iou_wren(iou_wren), .iou_data_read(iou_data_read)
  );

  typedef struct packed {
    logic        rst;
    logic        alive;
    logic        cr;
    logic        cw;
    logic [31:0] ca;
    logic [31:0] cd;
    logic        mr;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
    logic [31:0] rd;
  } in_t;

  typedef struct {
    in_t         in;
    logic        en;
    logic [31:0] addr;
    logic        cack;
    logic        cbusy;
    logic [31:0] cdr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: pending requests plus the timeline of the one access in flight.
  logic        pv[2];
  logic [31:0] pa[2], pd[2];
  logic        pw[2];
  logic [31:0] m_dr[2];
  logic        m_ovr[2];
  int          m_issue, m_ack, m_free, m_own;
  logic        m_last_mau, m_iw;
  logic [31:0] m_ia, m_id;
  logic [31:0] hist[0:4095];

  // Observations
  logic [135:0] o_vec;
  int           en_cyc[$];
  logic [31:0]  en_addr[$], en_data[$];
  logic         en_wr[$];
  int           cpu_acks, mau_acks;

  function automatic in_t mk(input logic rst, a, cr, cw, input logic [31:0] ca, cd,
                             input logic mr, mw, input logic [31:0] ma, md, rd);
    in_t v;
    v = '{rst: rst, alive: a, cr: cr, cw: cw, ca: ca, cd: cd, mr: mr, mw: mw, ma: ma, md: md,
          rd: rd};
    return v;
  endfunction

  function automatic in_t idle_in(input logic a);
    return mk(1'b0, a, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
  endfunction

  function automatic void model_reset(input int next);
    for (int r = 0; r < 2; r++) begin
      pv[r] = 1'b0; pa[r] = '0; pd[r] = '0; pw[r] = 1'b0; m_dr[r] = '0; m_ovr[r] = 1'b0;
    end
    m_issue = -1; m_ack = -1; m_free = next; m_own = 0;
    m_last_mau = 1'b1; m_iw = 1'b0; m_ia = '0; m_id = '0;
  endfunction

  function automatic logic [135:0] exp_vec();
    logic en;
    en = (cyc == m_issue);
    return {pv[0], pv[1], (cyc == m_ack) && (m_own == 0), (cyc == m_ack) && (m_own == 1),
            m_ovr[0], m_ovr[1], m_dr[0], m_dr[1], en, en ? m_ia : 32'h0, en ? m_id : 32'h0,
            en & m_iw};
  endfunction

  function automatic void model_step(input in_t v);
    int n;
    logic ce, me;
    int pick;
    n = cyc;
    if (v.rst) begin
      model_reset(n + 1);
      return;
    end
    if (n >= m_free) begin
      ce = pv[0] && v.alive;
      me = pv[1];
      if (ce || me) begin
        pick = (ce && me) ? (m_last_mau ? 0 : 1) : (me ? 1 : 0);
        m_own = pick; m_last_mau = (pick == 1);
        m_issue = n + 1; m_ack = n + 2 + L; m_free = n + 3 + L;
        m_ia = pa[pick]; m_id = pd[pick]; m_iw = pw[pick];
      end
    end
    if (v.cr) begin
      if (pv[0]) m_ovr[0] = 1'b1;
      else begin pv[0] = 1'b1; pa[0] = v.ca; pd[0] = v.cd; pw[0] = v.cw; end
    end
    if (v.mr) begin
      if (pv[1]) m_ovr[1] = 1'b1;
      else begin pv[1] = 1'b1; pa[1] = v.ma; pd[1] = v.md; pw[1] = v.mw; end
    end
    // The requester is free again in its ack cycle; read data is whatever the final WAIT saw.
    if (n + 1 == m_ack) begin
      pv[m_own] = 1'b0;
      if (!m_iw) m_dr[m_own] = hist[n % 4096];
    end
  endfunction

  task automatic chk(input string name, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_obs();
    en_cyc.delete(); en_addr.delete(); en_data.delete(); en_wr.delete();
    cpu_acks = 0; mau_acks = 0;
  endtask

  // Drives one cycle of inputs, compares against the model at the falling edge, then advances.
  task automatic step(input in_t v);
    logic [135:0] e;
    reset = v.rst; alive = v.alive;
    cpu_req = v.cr; cpu_wren = v.cw; cpu_address = v.ca; cpu_data_write = v.cd;
    mau_req = v.mr; mau_wren = v.mw; mau_address = v.ma; mau_data_write = v.md;
    iou_data_read = v.rd;
    hist[cyc % 4096] = v.rd;
    @(negedge clk);
    o_vec = {cpu_busy, mau_busy, cpu_ack, mau_ack, cpu_overrun, mau_overrun, cpu_data_read,
             mau_data_read, iou_clk_en, iou_address, iou_data_write, iou_wren};
    e = exp_vec();
    checks++;
    if (o_vec !== e) begin
      errors++;
      $display("FAIL model cyc=%0d: got %h expected %h", cyc, o_vec, e);
    end
    if (iou_clk_en) begin
      en_cyc.push_back(cyc); en_addr.push_back(iou_address);
      en_data.push_back(iou_data_write); en_wr.push_back(iou_wren);
    end
    if (cpu_ack) cpu_acks++;
    if (mau_ack) mau_acks++;
    model_step(v);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t tbl[6];
  int   t0;

  initial begin
    model_reset(0);
    clear_obs();
    reset = 1'b1; alive = 1'b1; cpu_req = 1'b0; mau_req = 1'b0; cpu_wren = 1'b0;
    mau_wren = 1'b0; cpu_address = '0; cpu_data_write = '0; mau_address = '0;
    mau_data_write = '0; iou_data_read = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state and first CPU read (address 0x4, data 0xA5, L=1).
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
    chk("reset_state", o_vec, '0);
    tbl[0] = '{mk(0, 1, 1, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5), 0, 32'h0, 0, 0, 32'h0};
    tbl[1] = '{mk(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5), 0, 32'h0, 0, 1, 32'h0};
    tbl[2] = '{mk(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5), 1, 32'h4, 0, 1, 32'h0};
    tbl[3] = '{mk(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5), 0, 32'h0, 0, 1, 32'h0};
    tbl[4] = '{mk(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5), 0, 32'h0, 1, 0, 32'hA5};
    tbl[5] = '{mk(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5), 0, 32'h0, 0, 0, 32'hA5};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].in);
      chk($sformatf("tbl%0d", i), {108'h0, iou_clk_en_o(), iou_addr_o(), cpu_ack_o(),
          cpu_busy_o(), cpu_dr_o()},
          {108'h0, tbl[i].en, tbl[i].addr, tbl[i].cack, tbl[i].cbusy, tbl[i].cdr});
    end

    // Simultaneous requests after reset: CPU first, MAU 3+L cycles later.
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clear_obs();
    t0 = cyc;
    step(mk(0, 1, 1, 0, 32'h100, 32'h0, 1, 0, 32'h200, 32'h0, $urandom));
    for (int i = 0; i < 12; i++) step(idle_in(1'b1));
    chk("both_en_count", 136'(en_cyc.size()), 136'd2);
    if (en_cyc.size() >= 2) begin
      chk("both_cpu_en_cyc", 136'(en_cyc[0] - t0), 136'd2);
      chk("both_cpu_addr", 136'(en_addr[0]), 136'h100);
      chk("both_mau_gap", 136'(en_cyc[1] - en_cyc[0]), 136'(3 + L));
      chk("both_mau_addr", 136'(en_addr[1]), 136'h200);
    end
    chk("both_cpu_acks", 136'(cpu_acks), 136'd1);
    chk("both_mau_acks", 136'(mau_acks), 136'd1);

    // alive=0: CPU request stays parked while the MAU is served.
    clear_obs();
    step(mk(0, 0, 1, 0, 32'h300, 32'h0, 0, 0, 32'h0, 32'h0, $urandom));
    step(idle_in(1'b0));
    step(mk(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h400, 32'h0, $urandom));
    for (int i = 0; i < 12; i++) step(idle_in(1'b0));
    chk("dead_en_count", 136'(en_cyc.size()), 136'd1);
    if (en_cyc.size() >= 1) chk("dead_mau_addr", 136'(en_addr[0]), 136'h400);
    chk("dead_cpu_busy", 136'(o_vec[135]), 136'd1);
    chk("dead_cpu_acks", 136'(cpu_acks), 136'd0);
    chk("dead_mau_acks", 136'(mau_acks), 136'd1);
    for (int i = 0; i < 8; i++) step(idle_in(1'b1));
    chk("alive_cpu_acks", 136'(cpu_acks), 136'd1);

    // Write then overrun: only the first request ever reaches the IO unit.
    clear_obs();
    step(mk(0, 1, 1, 1, 32'h30, 32'h3C, 0, 0, 32'h0, 32'h0, $urandom));
    step(mk(0, 1, 1, 0, 32'h34, 32'h77, 0, 0, 32'h0, 32'h0, $urandom));
    for (int i = 0; i < 10; i++) step(idle_in(1'b1));
    chk("ovr_en_count", 136'(en_cyc.size()), 136'd1);
    if (en_cyc.size() >= 1) begin
      chk("ovr_wdata", 136'(en_data[0]), 136'h3C);
      chk("ovr_wren", 136'(en_wr[0]), 136'd1);
    end
    chk("ovr_flag", 136'(o_vec[131]), 136'd1);
    chk("ovr_cpu_acks", 136'(cpu_acks), 136'd1);

    // Reset during WAIT aborts the access; the next request is served normally.
    clear_obs();
    step(mk(0, 1, 1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0, $urandom));
    step(idle_in(1'b1));
    step(idle_in(1'b1));
    step(mk(1, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, $urandom));
    step(idle_in(1'b1));
    chk("rst_wait_zero", o_vec, '0);
    for (int i = 0; i < 4; i++) step(idle_in(1'b1));
    chk("rst_wait_no_ack", 136'(cpu_acks), 136'd0);
    step(mk(0, 1, 1, 0, 32'h60, 32'h0, 0, 0, 32'h0, 32'h0, $urandom));
    for (int i = 0; i < 6; i++) step(idle_in(1'b1));
    chk("rst_wait_recover", 136'(cpu_acks), 136'd1);

    // Random traffic against the model.
    begin
      logic a;
      a = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 29) == 0) a = ~a;
        step(mk(($urandom_range(0, 199) == 0), a, ($urandom_range(0, 4) == 0), 1'($urandom),
                $urandom, $urandom, ($urandom_range(0, 4) == 0), 1'($urandom), $urandom,
                $urandom, $urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic iou_clk_en_o();
    return o_vec[65];
  endfunction
  function automatic logic [31:0] iou_addr_o();
    return o_vec[64:33];
  endfunction
  function automatic logic cpu_ack_o();
    return o_vec[133];
  endfunction
  function automatic logic cpu_busy_o();
    return o_vec[135];
  endfunction
  function automatic logic [31:0] cpu_dr_o();
    return o_vec[129:98];
  endfunction

endmodule

// File: doc/iou_arbiter.md
IOU_ARBITER -- requirements
Module: iou_arbiter

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1: cycles from iou_clk_en pulse to valid iou_data_read; legal range 1..7.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 alive  in  1  0 = MAU-only mode, 1 = CPU and MAU share the port.
REQ-006 cpu_req / mau_req  in  1  single-cycle request pulse; address, data and wren captured on that cycle.
REQ-007 cpu_address / mau_address  in  32  request address, passed through unmodified.
REQ-008 cpu_data_write / mau_data_write  in  32  write data.
REQ-009 cpu_wren / mau_wren  in  1  1 = write, 0 = read.
REQ-010 cpu_busy / mau_busy  out  1  request pending or in flight for that requester.
REQ-011 cpu_ack / mau_ack  out  1  one-cycle completion pulse.
REQ-012 cpu_data_read / mau_data_read  out  32  read result; held until that requester's next ack.
REQ-013 cpu_overrun / mau_overrun  out  1  sticky flag: request dropped while busy.
REQ-014 iou_clk_en  out  1  one-cycle access strobe to the IO unit.
REQ-015 iou_address / iou_data_write  out  32  granted request fields.
REQ-016 iou_wren  out  1  granted request write enable.
REQ-017 iou_data_read  in  32  IO unit read data.

Function
REQ-018 Each requester SHALL have one pending slot (valid, address, data, wren), loaded on a req pulse when busy=0.
REQ-019 busy SHALL be 1 from the cycle after an accepted req through the cycle before that requester's ack; busy is 0 in the ack cycle, so a req in the ack cycle is accepted.
REQ-020 A req while busy=1 SHALL be dropped without disturbing the slot and SHALL set overrun, which is cleared only by reset.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-022 IDLE -> ISSUE when any eligible slot is valid; the grant is decided only in IDLE; otherwise the FSM stays in IDLE.
REQ-023 Eligibility: alive=0 makes only the MAU eligible, and a CPU slot stays pending without being granted; alive=1 makes both eligible.
REQ-024 Both eligible: round-robin grant to the requester not granted last; the last-grant register resets to MAU, so the CPU wins the first tie.
REQ-025 ISSUE lasts exactly one cycle: iou_clk_en=1 and the iou_* outputs carry the granted slot; the granted slot is cleared at the end of ISSUE.
REQ-026 WAIT SHALL count READ_LATENCY cycles, capture iou_data_read at the end of the final WAIT cycle, then go to RESP.
REQ-027 RESP lasts one cycle: the granted requester's ack=1; its data_read is updated to the captured value for a read and left unchanged for a write; then RESP -> IDLE.
REQ-028 Writes SHALL use the same ISSUE/WAIT/RESP timing as reads.
REQ-029 iou_clk_en, iou_wren, iou_address and iou_data_write SHALL be 0 outside ISSUE.
REQ-030 An alive change mid-transaction SHALL NOT abort the in-flight access; it affects only the next IDLE decision.
REQ-031 Latency from a req pulse in cycle T on an idle arbiter (READ_LATENCY=L) SHALL be: iou_clk_en in T+2, ack in T+3+L.
REQ-032 Same-cycle req pulses from both requesters SHALL both be accepted and then served back-to-back per REQ-024.

Reset
REQ-033 Reset SHALL set the FSM to IDLE, clear both slots, set last-grant to MAU, and drive every output to 0 (busy, ack, overrun, data_read, all iou_*).
REQ-034 Reset mid-transaction SHALL abort the access with no ack; reset has priority over any simultaneous req.

Verification
REQ-035 alive=1, CPU read pulse at cycle 0 with address 0x4, L=1, iou_data_read=0xA5 -> iou_clk_en in cycle 2 with iou_address=0x4, cpu_ack in cycle 4, cpu_data_read=0xA5.
REQ-036 alive=1, CPU and MAU req in the same cycle after reset -> CPU issued first, MAU issued 3+L cycles later, each acked exactly once.
REQ-037 alive=0, CPU req then MAU req -> only the MAU is served and cpu_busy stays 1; after alive goes to 1, the CPU is served.
REQ-038 CPU write 0x3C, then a second CPU req while busy -> one iou write with data 0x3C, cpu_overrun=1, the second request is never issued.
REQ-039 Reset asserted during WAIT -> no ack, all outputs 0 next cycle, a new req is served normally.
